// File: rtl/syncup_counter.sv
// rtl/syncup_counter.sv - Up-counter with wrap/one-shot modes, clear, load, cascade carry and done flag.
// Optional prescaler enabled by defining SYNCUP_PRESCALE_EN.
module syncup_counter #(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = 7,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    state_t state;
    logic   at_max;
    logic   step;

    assign at_max = (count == MAX);

`ifdef SYNCUP_PRESCALE_EN
    localparam int             PSW     = $clog2(PRESCALE);
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] ps;

    // Only the last enabled edge of each prescale window moves the count.
    assign step = en && (ps == PS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps <= '0;
        end else if (clr || load) begin
            ps <= '0;
        end else if (en && (state != DONE)) begin
            ps <= (ps == PS_LAST) ? '0 : ps + PSW'(1);
        end
    end
`else
    assign step = en;
`endif

    assign tc = step & at_max & (state != DONE) & ~clr & ~load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            state <= IDLE;
            done  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            state <= IDLE;
            done  <= 1'b0;
        end else if (load) begin
            count <= (load_val > MAX) ? MAX : load_val;
            state <= IDLE;
            done  <= 1'b0;
        end else if (step && (state != DONE)) begin
            if (!at_max) begin
                count <= count + WIDTH'(1);
                state <= RUN;
            end else if (one_shot) begin
                // Hold at the terminal value until clr or load.
                state <= DONE;
                done  <= 1'b1;
            end else begin
                count <= '0;
                state <= RUN;
            end
        end
    end

endmodule
